// File: rtl/jstepper_if.sv
// Control-side bundle of the instruction stepper: halt/restart requests in,
// one-hot step lines, clock phases and status out.
interface jstepper_if #(
    parameter int N = 6
);
    logic         halt;
    logic         restart;
    logic [N-1:0] bos;
    logic         clk_e;
    logic         clk_s;
    logic         done;
    logic         running;

    modport master (
        output halt, restart,
        input  bos, clk_e, clk_s, done, running
    );

    modport slave (
        input  halt, restart,
        output bos, clk_e, clk_s, done, running
    );
endinterface

// File: rtl/jstepper.sv
// Instruction stepper: one-hot step lines plus nested enable/set phases,
// four phase ticks per step, with halt parking at instruction boundaries.
//
//   mode   | meaning
//   -------+-----------------------------------------------------------
//   S_RUN  | dividing clk into phase ticks and walking the steps
//   S_PARK | halted in step 1, phase 0; resumes in phase 1 once halt drops
module jstepper #(
    parameter int N   = 6,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    jstepper_if.slave    sif
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(N);
    localparam logic [DW-1:0] DV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(N - 1);

    typedef enum logic {S_RUN, S_PARK} mode_t;

    mode_t         mode_q, mode_d;
    logic [DW-1:0] dv_q, dv_d;
    logic [1:0]    ph_q, ph_d;
    logic [SW-1:0] st_q, st_d;
    logic          rp_q, rp_d;
    logic          done_q, done_d;
    logic          tick, boundary, wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= S_RUN;
            dv_q   <= '0;
            ph_q   <= 2'd0;
            st_q   <= '0;
            rp_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dv_q   <= dv_d;
            ph_q   <= ph_d;
            st_q   <= st_d;
            rp_q   <= rp_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        dv_d     = dv_q;
        ph_d     = ph_q;
        st_d     = st_q;
        rp_d     = rp_q | sif.restart;
        done_d   = 1'b0;
        tick     = (mode_q == S_RUN) && (dv_q == DV_LAST);
        boundary = tick && (ph_q == 2'd3);
        wrap     = 1'b0;
        case (mode_q)
            S_RUN: begin
                dv_d = tick ? '0 : dv_q + DW'(1);
                if (tick)
                    ph_d = ph_q + 2'd1;
                if (boundary) begin
                    // A restart seen in the boundary cycle itself is consumed here too.
                    if (rp_q || sif.restart) begin
                        wrap = 1'b1;
                        rp_d = 1'b0;
                    end else if (st_q == ST_LAST) begin
                        wrap = 1'b1;
                    end else begin
                        st_d = st_q + SW'(1);
                    end
                    if (wrap) begin
                        st_d   = '0;
                        done_d = 1'b1;
                        if (sif.halt)
                            mode_d = S_PARK;
                    end
                end
            end
            S_PARK: begin
                dv_d = '0;
                if (!sif.halt) begin
                    mode_d = S_RUN;
                    ph_d   = 2'd1;
                end
            end
            default: mode_d = S_RUN;
        endcase
    end

    always_comb begin
        sif.bos = '0;
        for (int i = 0; i < N; i++)
            sif.bos[i] = (st_q == SW'(i));
        sif.clk_e   = (ph_q == 2'd1) || (ph_q == 2'd2);
        sif.clk_s   = (ph_q == 2'd2);
        sif.done    = done_q;
        sif.running = (mode_q == S_RUN);
    end
endmodule

// File: tb/tb_jstepper.sv
// Bench for jstepper: DIV=1 and DIV=2 instances driven in parallel, checked
// every cycle against a step-position model plus a table of directed points.
module tb_jstepper;
    localparam int N = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halt = 1'b0;
    logic restart = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jstepper_if #(.N(N)) ifa ();
    jstepper_if #(.N(N)) ifb ();
    assign ifa.halt    = halt;
    assign ifa.restart = restart;
    assign ifb.halt    = halt;
    assign ifb.restart = restart;

    jstepper #(.N(N), .DIV(1)) dut_a (.clk(clk), .reset(reset), .sif(ifa));
    jstepper #(.N(N), .DIV(2)) dut_b (.clk(clk), .reset(reset), .sif(ifb));

    // Model: position within the current step in clk cycles, step number,
    // pending restart and parked flag.
    typedef struct {
        int pos;
        int step;
        bit pend;
        bit parked;
        bit done;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_next(mdl_t m, int div, bit r, bit h, bit rs);
        mdl_t n = m;
        n.done = 1'b0;
        if (r) begin
            n.pos = 0; n.step = 0; n.pend = 1'b0; n.parked = 1'b0;
            return n;
        end
        if (m.parked) begin
            n.pend = m.pend | rs;
            if (!h) begin
                n.parked = 1'b0;
                n.pos    = div;
            end
            return n;
        end
        if (m.pos == 4 * div - 1) begin
            n.pos = 0;
            if (m.pend || rs || m.step == N - 1) begin
                n.step   = 0;
                n.done   = 1'b1;
                n.pend   = 1'b0;
                n.parked = h;
            end else begin
                n.step = m.step + 1;
            end
        end else begin
            n.pos  = m.pos + 1;
            n.pend = m.pend | rs;
        end
        return n;
    endfunction

    function automatic logic [9:0] mdl_out(mdl_t m, int div);
        logic [N-1:0] b = '0;
        int phase = m.pos / div;
        b[m.step] = 1'b1;
        return {b, !m.parked && (phase == 1 || phase == 2),
                !m.parked && phase == 2, m.done, !m.parked};
    endfunction

    function automatic logic [9:0] dut_out(int which);
        if (which == 0)
            return {ifa.bos, ifa.clk_e, ifa.clk_s, ifa.done, ifa.running};
        return {ifb.bos, ifb.clk_e, ifb.clk_s, ifb.done, ifb.running};
    endfunction

    task automatic chk(string name, int cyc, logic [9:0] act, logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got bos=%b e/s/done/run=%b want bos=%b e/s/done/run=%b",
                     name, cyc, act[9:4], act[3:0], exp[9:4], exp[3:0]);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        ma = mdl_next(ma, 1, reset, halt, restart);
        mb = mdl_next(mb, 2, reset, halt, restart);
        @(negedge clk);
    endtask

    typedef struct {
        int len;
        int rs_cyc;
        int h_lo;
        int h_hi;
        int rst_cyc;
    } scn_t;

    typedef struct {
        int         scen;
        int         dut;
        int         cyc;
        logic [9:0] exp;   // {bos, clk_e, clk_s, done, running}
    } vec_t;

    scn_t sc[4];
    vec_t vt[$];
    int   hits = 0;

    task automatic do_reset();
        reset = 1'b1; halt = 1'b0; restart = 1'b0;
        step_clk();
        step_clk();
        reset = 1'b0;
    endtask

    initial begin
        ma = '{0, 0, 1'b0, 1'b0, 1'b0};
        mb = ma;
        sc[0] = '{50, -1, -1, -1, -1};
        sc[1] = '{20,  5, -1, -1, -1};
        sc[2] = '{45, -1, 10, 33, -1};
        sc[3] = '{30, 11, -1, -1, 13};

        // free run
        vt.push_back('{0, 0,  0, {6'b000001, 4'b0001}});
        vt.push_back('{0, 0,  1, {6'b000001, 4'b1001}});
        vt.push_back('{0, 0,  2, {6'b000001, 4'b1101}});
        vt.push_back('{0, 0,  3, {6'b000001, 4'b0001}});
        vt.push_back('{0, 0,  4, {6'b000010, 4'b0001}});
        vt.push_back('{0, 0, 23, {6'b100000, 4'b0001}});
        vt.push_back('{0, 0, 24, {6'b000001, 4'b0011}});
        vt.push_back('{0, 0, 25, {6'b000001, 4'b1001}});
        vt.push_back('{0, 0, 48, {6'b000001, 4'b0011}});
        vt.push_back('{0, 1,  2, {6'b000001, 4'b1001}});
        vt.push_back('{0, 1,  4, {6'b000001, 4'b1101}});
        vt.push_back('{0, 1,  5, {6'b000001, 4'b1101}});
        vt.push_back('{0, 1,  6, {6'b000001, 4'b0001}});
        vt.push_back('{0, 1,  8, {6'b000010, 4'b0001}});
        vt.push_back('{0, 1, 47, {6'b100000, 4'b0001}});
        vt.push_back('{0, 1, 48, {6'b000001, 4'b0011}});
        // restart pulse at cycle 5
        vt.push_back('{1, 0,  7, {6'b000010, 4'b0001}});
        vt.push_back('{1, 0,  8, {6'b000001, 4'b0011}});
        vt.push_back('{1, 0, 12, {6'b000010, 4'b0001}});
        vt.push_back('{1, 1,  8, {6'b000001, 4'b0011}});
        // halt 10..33
        vt.push_back('{2, 0, 24, {6'b000001, 4'b0010}});
        vt.push_back('{2, 0, 25, {6'b000001, 4'b0000}});
        vt.push_back('{2, 0, 34, {6'b000001, 4'b0000}});
        vt.push_back('{2, 0, 35, {6'b000001, 4'b1001}});
        vt.push_back('{2, 0, 36, {6'b000001, 4'b1101}});
        vt.push_back('{2, 0, 38, {6'b000010, 4'b0001}});
        // reset at 13 with restart pending
        vt.push_back('{3, 1, 13, {6'b000010, 4'b1101}});
        vt.push_back('{3, 1, 14, {6'b000001, 4'b0001}});
        vt.push_back('{3, 1, 16, {6'b000001, 4'b1001}});
        vt.push_back('{3, 1, 22, {6'b000010, 4'b0001}});
        vt.push_back('{3, 0, 14, {6'b000001, 4'b0001}});
        vt.push_back('{3, 0, 18, {6'b000010, 4'b0001}});

        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int c = 0; c < sc[s].len; c++) begin
                halt    = (c >= sc[s].h_lo) && (c <= sc[s].h_hi);
                restart = (c == sc[s].rs_cyc);
                reset   = (c == sc[s].rst_cyc);
                chk("model_a", c, dut_out(0), mdl_out(ma, 1));
                chk("model_b", c, dut_out(1), mdl_out(mb, 2));
                foreach (vt[i]) begin
                    if (vt[i].scen == s && vt[i].cyc == c) begin
                        hits++;
                        chk($sformatf("vec%0d", i), c, dut_out(vt[i].dut), vt[i].exp);
                    end
                end
                step_clk();
            end
        end
        checks++;
        if (hits != vt.size()) begin
            errors++;
            $display("FAIL table_hits: got %0d want %0d", hits, vt.size());
        end

        do_reset();
        for (int c = 0; c < 1500; c++) begin
            restart = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 47) == 0)
                halt = ~halt;
            reset = ($urandom_range(0, 399) == 0);
            chk("rand_a", c, dut_out(0), mdl_out(ma, 1));
            chk("rand_b", c, dut_out(1), mdl_out(mb, 2));
            step_clk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
